// File: rtl/sd_bd_pkg.sv
// Shared constants and read-FSM encoding for the SD buffer-descriptor queue.
package sd_bd_pkg;
  localparam int BD_WORDS  = 2;
  localparam int WORD_SADR = 0;
  localparam int WORD_CARG = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_t;
endpackage

// File: rtl/sd_bd_dpram.sv
// Simple dual-port descriptor store: host writes, master reads through a registered port.
module sd_bd_dpram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read register doubles as the master data output, so it holds between reads.
  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sd_bd_queue.sv
// Circular BD queue: host fills 2-word descriptors, SD data master reads them with re/ack
// and retires the head with a_cmp_s. free_bd==BD_DEPTH means empty.
module sd_bd_queue
  import sd_bd_pkg::*;
#(
  parameter int BD_DEPTH  = 8,
  parameter int MEM_WIDTH = 32,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bd_clr,
  input  logic                 we_m,
  input  logic [MEM_WIDTH-1:0] dat_in_m,
  output logic                 new_bw,
  output logic                 wr_ovf,
  output logic [CNT_WIDTH-1:0] free_bd,
  input  logic                 re_s,
  output logic                 ack_o_s,
  output logic [MEM_WIDTH-1:0] dat_out_s,
  input  logic                 a_cmp_s
);
  localparam int PTR_W = (BD_DEPTH > 1) ? $clog2(BD_DEPTH) : 1;
  localparam int AW    = PTR_W + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(BD_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(BD_DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_half;
  logic [1:0]       rd_word, word_eff;
  logic             re_q;
  rd_state_t        state;

  logic clr, avail, accept, commit, retire, re_rise, issue;

  assign clr      = rst | bd_clr;
  assign avail    = (free_bd != DEPTH_CNT);
  assign accept   = we_m && (free_bd != '0);
  assign commit   = accept && wr_half;
  assign retire   = a_cmp_s && avail;
  assign re_rise  = re_s && !re_q;
  // A fresh re_s edge restarts the session at word0 before deciding whether to issue.
  assign word_eff = re_rise ? 2'd0 : rd_word;
  assign issue    = (state == RD_IDLE) && re_s && avail && (word_eff < 2'd2) && !retire;

  sd_bd_dpram #(.DEPTH(BD_WORDS * BD_DEPTH), .AW(AW), .DW(MEM_WIDTH)) u_ram (
    .clk   (clk),
    .rst   (clr),
    .we    (accept),
    .waddr ({wr_ptr, wr_half}),
    .wdata (dat_in_m),
    .re    (issue),
    .raddr ({rd_ptr, word_eff[0]}),
    .rdata (dat_out_s)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_half <= 1'b0;
      rd_word <= 2'd0;
      re_q    <= 1'b0;
      free_bd <= DEPTH_CNT;
      new_bw  <= 1'b0;
      wr_ovf  <= 1'b0;
      ack_o_s <= 1'b0;
      state   <= RD_IDLE;
    end else begin
      new_bw <= accept;
      wr_ovf <= we_m && !accept;
      re_q   <= re_s;

      if (accept) begin
        if (wr_half) begin
          wr_half <= 1'b0;
          wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end else begin
          wr_half <= 1'b1;
        end
      end

      if (retire) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      case ({commit, retire})
        2'b10:   free_bd <= free_bd - 1'b1;
        2'b01:   free_bd <= free_bd + 1'b1;
        default: free_bd <= free_bd;
      endcase

      if (retire)       rd_word <= 2'd0;
      else if (issue)   rd_word <= word_eff + 2'd1;
      else if (re_rise) rd_word <= 2'd0;

      case (state)
        RD_IDLE: begin
          ack_o_s <= issue;
          if (issue) state <= RD_ACK;
        end
        RD_ACK: begin
          ack_o_s <= 1'b0;
          state   <= RD_IDLE;
        end
        default: begin
          ack_o_s <= 1'b0;
          state   <= RD_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_bd_queue.sv
// Scoreboarded bench for sd_bd_queue: a BD model predicts read data and free_bd.
module tb_sd_bd_queue;
  logic        clk = 1'b0;
  logic        rst, bd_clr, we_m, re_s, a_cmp_s;
  logic [31:0] dat_in_m, dat_out_s;
  logic        new_bw, wr_ovf, ack_o_s;
  logic [3:0]  free_bd;

  sd_bd_queue #(.BD_DEPTH(8), .MEM_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .bd_clr(bd_clr), .we_m(we_m), .dat_in_m(dat_in_m),
    .new_bw(new_bw), .wr_ovf(wr_ovf), .free_bd(free_bd), .re_s(re_s),
    .ack_o_s(ack_o_s), .dat_out_s(dat_out_s), .a_cmp_s(a_cmp_s)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, n_ack = 0, a;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [16];
  int          m_wp, m_rp, m_half, m_free;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_half = 0; m_free = 8;
  endtask

  // One cycle of host write and/or retire, with model update and output checks.
  task automatic step(input bit we, input logic [31:0] d, input bit cmp);
    bit acc, ret, cm;
    acc = we && (m_free != 0);
    ret = cmp && (m_free != 8);
    cm  = acc && (m_half == 1);
    we_m = we; dat_in_m = d; a_cmp_s = cmp;
    if (acc) begin
      mdl[m_wp*2 + m_half] = d;
      if (m_half == 1) begin m_half = 0; m_wp = (m_wp + 1) % 8; end
      else m_half = 1;
    end
    if (ret) m_rp = (m_rp + 1) % 8;
    m_free = m_free + (ret ? 1 : 0) - (cm ? 1 : 0);
    tick();
    we_m = 1'b0; a_cmp_s = 1'b0;
    chk("new_bw", 32'(new_bw), 32'(acc));
    chk("wr_ovf", 32'(wr_ovf), 32'(we && !acc));
    chk("free_bd", 32'(free_bd), 32'(m_free));
  endtask

  // Fresh read session on the head BD: both words, ack timing checked.
  task automatic rd_bd();
    re_s = 1'b0; tick();
    re_s = 1'b1;
    exp_q.push_back(mdl[m_rp*2]);
    tick(); chk("ack_w0", 32'(ack_o_s), 1);
    tick(); chk("ack_gap", 32'(ack_o_s), 0);
    exp_q.push_back(mdl[m_rp*2 + 1]);
    tick(); chk("ack_w1", 32'(ack_o_s), 1);
    re_s = 1'b0; tick();
  endtask

  always @(negedge clk)
    if (ack_o_s === 1'b1) begin
      n_ack++;
      if (exp_q.size() == 0) chk("ack_unexp", 32'(ack_o_s), 0);
      else chk("rd_data", dat_out_s, exp_q.pop_front());
    end

  initial begin
    rst = 1'b1; bd_clr = 1'b0; we_m = 1'b0; re_s = 1'b0; a_cmp_s = 1'b0; dat_in_m = '0;
    model_reset();
    tick(); tick();
    chk("rst_free", 32'(free_bd), 8);
    chk("rst_ack", 32'(ack_o_s), 0);
    chk("rst_new_bw", 32'(new_bw), 0);
    chk("rst_wr_ovf", 32'(wr_ovf), 0);
    chk("rst_dat", dat_out_s, 0);
    rst = 1'b0;

    // Read request with an empty queue.
    re_s = 1'b1; a = n_ack;
    repeat (4) tick();
    chk("empty_noack", 32'(n_ack), 32'(a));
    re_s = 1'b0; tick();

    // One BD, then read both words with re_s held.
    step(1'b1, 32'h1000_0000, 1'b0);
    step(1'b1, 32'h0000_0200, 1'b0);
    re_s = 1'b1;
    exp_q.push_back(mdl[0]);
    tick(); chk("hold_ack0", 32'(ack_o_s), 1);
    tick(); chk("hold_gap", 32'(ack_o_s), 0);
    exp_q.push_back(mdl[1]);
    tick(); chk("hold_ack1", 32'(ack_o_s), 1);
    tick(); a = n_ack;
    repeat (10) tick();
    chk("hold_noack", 32'(n_ack), 32'(a));

    // Retry re-reads word0, then retire.
    re_s = 1'b0; tick();
    re_s = 1'b1;
    exp_q.push_back(mdl[m_rp*2]);
    tick(); chk("retry_ack", 32'(ack_o_s), 1);
    re_s = 1'b0; tick();
    step(1'b0, 32'h0, 1'b1);

    // Fill, overflow, simultaneous events.
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'hdead_beef, 1'b0);
    rd_bd();
    step(1'b1, 32'hbad0_0001, 1'b1);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    while (m_free != 8) begin
      rd_bd();
      step(1'b0, 32'h0, 1'b1);
    end
    // Three laps of the pointers.
    repeat (24) begin
      step(1'b1, $urandom, 1'b0);
      step(1'b1, $urandom, 1'b0);
      rd_bd();
      step(1'b0, 32'h0, 1'b1);
    end

    // Soft clear discards a half-written BD.
    step(1'b1, 32'h5555_0000, 1'b0);
    bd_clr = 1'b1; tick(); bd_clr = 1'b0;
    model_reset();
    chk("clr_free", 32'(free_bd), 8);
    step(1'b1, 32'ha0a0_0001, 1'b0);
    step(1'b1, 32'hb0b0_0002, 1'b0);
    rd_bd();

    // Reset while an ack is being presented.
    re_s = 1'b0; tick();
    re_s = 1'b1;
    exp_q.push_back(mdl[0]);
    tick(); chk("pre_rst_ack", 32'(ack_o_s), 1);
    rst = 1'b1; re_s = 1'b0;
    tick(); rst = 1'b0;
    model_reset();
    chk("rst_ack_drop", 32'(ack_o_s), 0);
    chk("rst_dat_clr", dat_out_s, 0);
    chk("rst_free2", 32'(free_bd), 8);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
